// File: rtl/ast_width_downsizer_pkg.sv
// Shared widths, typedefs and FSM encoding for the Avalon-ST width downsizer.
package ast_width_downsizer_pkg;

    function automatic int empty_width(input int data_w);
        return ($clog2(data_w / 8) == 0) ? 1 : $clog2(data_w / 8);
    endfunction

    localparam int DATA_IN_W   = 128;
    localparam int DATA_OUT_W  = 64;
    localparam int CHANNEL_W   = 10;
    localparam int EMPTY_IN_W  = empty_width(DATA_IN_W);
    localparam int EMPTY_OUT_W = empty_width(DATA_OUT_W);

    typedef logic [DATA_IN_W-1:0]  data_t;
    typedef logic [CHANNEL_W-1:0]  channel_t;
    typedef logic [EMPTY_IN_W-1:0] empty_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/ast_beat_sel.sv
// Combinational beat selector: picks the output slice of the held word and
// derives the beat count, last-beat flag and source empty for EOP words.
module ast_beat_sel
    import ast_width_downsizer_pkg::*;
#(
    parameter int DATA_IN_W   = 128,
    parameter int DATA_OUT_W  = 64,
    parameter int EMPTY_IN_W  = 4,
    parameter int EMPTY_OUT_W = 3,
    parameter int BEAT_W      = 1
) (
    input  logic [DATA_IN_W-1:0]   buf_data,
    input  logic [BEAT_W-1:0]      beat_idx,
    input  logic [EMPTY_IN_W-1:0]  empty_in,
    input  logic                   eop,
    output logic [DATA_OUT_W-1:0]  slice,
    output logic [EMPTY_OUT_W-1:0] empty_out,
    output logic                   last_beat
);

    localparam int R         = DATA_IN_W / DATA_OUT_W;
    localparam int BYTES_IN  = DATA_IN_W / 8;
    localparam int BYTES_OUT = DATA_OUT_W / 8;

    int valid_bytes;
    int beat_cnt;

    always_comb begin
        valid_bytes = BYTES_IN;
        beat_cnt    = R;
        // Only an EOP word may be short; empty is meaningless otherwise
        if (eop) begin
            valid_bytes = BYTES_IN - int'(empty_in);
            beat_cnt    = (valid_bytes + BYTES_OUT - 1) / BYTES_OUT;
            if (beat_cnt < 1) begin
                beat_cnt = 1;
            end
        end
        last_beat = (int'(beat_idx) == (beat_cnt - 1));
        empty_out = '0;
        if (eop && last_beat) begin
            empty_out = EMPTY_OUT_W'(beat_cnt * BYTES_OUT - valid_bytes);
        end
        slice = buf_data[int'(beat_idx) * DATA_OUT_W +: DATA_OUT_W];
    end

endmodule

// File: rtl/ast_width_downsizer.sv
// Avalon-ST width downsizer: one wide sink word becomes B narrow source beats.
// Optional feature macro: AST_DOWNSIZER_DROP_ORPHAN_EN (drop words outside a packet).
module ast_width_downsizer
    import ast_width_downsizer_pkg::*;
#(
    parameter int DATA_IN_W   = ast_width_downsizer_pkg::DATA_IN_W,
    parameter int DATA_OUT_W  = ast_width_downsizer_pkg::DATA_OUT_W,
    parameter int CHANNEL_W   = ast_width_downsizer_pkg::CHANNEL_W,
    parameter int EMPTY_IN_W  = empty_width(DATA_IN_W),
    parameter int EMPTY_OUT_W = empty_width(DATA_OUT_W)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int R      = DATA_IN_W / DATA_OUT_W;
    localparam int BEAT_W = (R > 1) ? $clog2(R) : 1;

    if ((R < 2) || ((R & (R - 1)) != 0) || ((DATA_IN_W % DATA_OUT_W) != 0)
        || ((DATA_OUT_W % 8) != 0)) begin : g_bad_cfg
        $error("ast_width_downsizer: DATA_IN_W/DATA_OUT_W must be a power of two >= 2");
    end

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    vld_p0;
    logic                    sink_xfer;
    logic                    src_xfer;
    logic                    load;
    logic                    last_beat;

    logic [DATA_IN_W-1:0]    buf_data_p0;
    logic [EMPTY_IN_W-1:0]   buf_empty_p0;
    logic [CHANNEL_W-1:0]    buf_chan_p0;
    logic                    buf_sop_p0;
    logic                    buf_eop_p0;

    logic [DATA_OUT_W-1:0]   sel_data;
    logic [EMPTY_OUT_W-1:0]  sel_empty;

    assign vld_p0      = (state_q == SEND) && !srst_i;
    assign ast_ready_o = !srst_i && ((state_q == IDLE) || (vld_p0 && last_beat && ast_ready_i));
    assign sink_xfer   = ast_valid_i && ast_ready_o;
    assign src_xfer    = vld_p0 && ast_ready_i;

`ifdef AST_DOWNSIZER_DROP_ORPHAN_EN
    logic in_pkt_q;

    // A word is only kept when it belongs to a packet opened by an SOP
    assign load = sink_xfer && (in_pkt_q || ast_startofpacket_i);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            in_pkt_q <= 1'b0;
        end else if (sink_xfer) begin
            in_pkt_q <= ast_endofpacket_i ? 1'b0 : (ast_startofpacket_i || in_pkt_q);
        end
    end
`else
    assign load = sink_xfer;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (src_xfer) begin
                    if (last_beat) begin
                        state_d = load ? SEND : IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Stage p0: holding buffer, masked at the outputs by vld_p0
    always_ff @(posedge clk_i) begin
        if (load) begin
            buf_data_p0  <= ast_data_i;
            buf_empty_p0 <= ast_empty_i;
            buf_chan_p0  <= ast_channel_i;
            buf_sop_p0   <= ast_startofpacket_i;
            buf_eop_p0   <= ast_endofpacket_i;
        end
    end

    ast_beat_sel #(
        .DATA_IN_W   (DATA_IN_W),
        .DATA_OUT_W  (DATA_OUT_W),
        .EMPTY_IN_W  (EMPTY_IN_W),
        .EMPTY_OUT_W (EMPTY_OUT_W),
        .BEAT_W      (BEAT_W)
    ) u_beat_sel (
        .buf_data  (buf_data_p0),
        .beat_idx  (beat_q),
        .empty_in  (buf_empty_p0),
        .eop       (buf_eop_p0),
        .slice     (sel_data),
        .empty_out (sel_empty),
        .last_beat (last_beat)
    );

    assign ast_valid_o         = vld_p0;
    assign ast_data_o          = vld_p0 ? sel_data : '0;
    assign ast_empty_o         = vld_p0 ? sel_empty : '0;
    assign ast_channel_o       = vld_p0 ? buf_chan_p0 : '0;
    assign ast_startofpacket_o = vld_p0 && buf_sop_p0 && (beat_q == '0);
    assign ast_endofpacket_o   = vld_p0 && buf_eop_p0 && last_beat;

endmodule

// File: tb/tb_ast_width_downsizer.sv
// Scoreboard bench for ast_width_downsizer: directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_ast_width_downsizer;
    import ast_width_downsizer_pkg::*;

    localparam int BYTES_IN  = DATA_IN_W / 8;
    localparam int BYTES_OUT = DATA_OUT_W / 8;

    typedef struct {
        logic [DATA_OUT_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_OUT_W-1:0] empty;
        channel_t               chan;
    } beat_s;

    logic                   clk;
    logic                   srst_i;
    data_t                  ast_data_i;
    logic                   ast_startofpacket_i;
    logic                   ast_endofpacket_i;
    logic                   ast_valid_i;
    empty_t                 ast_empty_i;
    channel_t               ast_channel_i;
    logic                   ast_ready_o;
    logic [DATA_OUT_W-1:0]  ast_data_o;
    logic                   ast_startofpacket_o;
    logic                   ast_endofpacket_o;
    logic                   ast_valid_o;
    logic [EMPTY_OUT_W-1:0] ast_empty_o;
    channel_t               ast_channel_o;
    logic                   ast_ready_i;

    beat_s exp_q[$];
    logic  rec_q[$];
    int    n_checks   = 0;
    int    n_pass     = 0;
    int    beats_seen = 0;
    int    ready_mode = 0;
    bit    rec_en     = 0;
    bit    in_pkt_m   = 0;

    ast_width_downsizer #(
        .DATA_IN_W   (DATA_IN_W),
        .DATA_OUT_W  (DATA_OUT_W),
        .CHANNEL_W   (CHANNEL_W),
        .EMPTY_IN_W  (EMPTY_IN_W),
        .EMPTY_OUT_W (EMPTY_OUT_W)
    ) dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference model: split a word into byte-counted beats
    task automatic model_word(input data_t d, input bit sop, input bit eop, input empty_t e, input channel_t ch);
        int    v;
        int    b;
        bit    keep;
        beat_s x;
        keep = 1'b1;
`ifdef AST_DOWNSIZER_DROP_ORPHAN_EN
        keep = in_pkt_m || sop;
        if (sop) in_pkt_m = 1'b1;
        if (eop) in_pkt_m = 1'b0;
`endif
        if (keep) begin
            v = eop ? (BYTES_IN - int'(e)) : BYTES_IN;
            b = (v + BYTES_OUT - 1) / BYTES_OUT;
            for (int n = 0; n < b; n++) begin
                x.data  = DATA_OUT_W'(d >> (n * DATA_OUT_W));
                x.sop   = sop && (n == 0);
                x.eop   = eop && (n == b - 1);
                x.empty = (eop && (n == b - 1)) ? EMPTY_OUT_W'(b * BYTES_OUT - v) : '0;
                x.chan  = ch;
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input data_t d, input bit sop, input bit eop, input empty_t e, input channel_t ch);
        bit acc;
        int guard;
        guard = 0;
        ast_data_i          = d;
        ast_startofpacket_i = sop;
        ast_endofpacket_i   = eop;
        ast_empty_i         = e;
        ast_channel_i       = ch;
        ast_valid_i         = 1'b1;
        forever begin
            @(negedge clk);
            acc = ast_ready_o;
            if (acc) model_word(d, sop, eop, e, ch);
            tick();
            if (acc) break;
            guard++;
            if (guard > 200) begin
                n_checks++;
                $display("FAIL send_timeout: ready_o low for %0d cycles, expected 1", guard);
                break;
            end
        end
        ast_valid_i         = 1'b0;
        ast_data_i          = '0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_empty_i         = '0;
        ast_channel_i       = '0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            tick();
            c++;
        end
        repeat (2) tick();
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Sink-side ready driver: 0 = low, 1 = high, 2 = random
    initial begin
        ast_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       ast_ready_i = 1'b0;
                1:       ast_ready_i = 1'b1;
                default: ast_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each source transfer
    initial begin
        beat_s       x;
        bit          prev_stall;
        logic [63:0] sv_data;
        logic [14:0] sv_ctl;
        prev_stall = 1'b0;
        sv_data    = '0;
        sv_ctl     = '0;
        forever begin
            @(negedge clk);
            if (rec_en) rec_q.push_back(ast_ready_o);
            if (prev_stall && !srst_i) begin
                check("stall_hold_valid", ast_valid_o, 1);
                check("stall_hold_data", ast_data_o, sv_data);
                check("stall_hold_ctl", {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, sv_ctl);
            end
            if (!ast_valid_o) begin
                check("idle_outputs_zero",
                      {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, 0);
            end else if (ast_ready_i) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", ast_data_o);
                end else begin
                    x = exp_q.pop_front();
                    check("beat_data", ast_data_o, x.data);
                    check("beat_sop_eop_empty_chan",
                          {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o},
                          {x.sop, x.eop, x.empty, x.chan});
                end
            end
            prev_stall = ast_valid_o && !ast_ready_i && !srst_i;
            sv_data    = ast_data_o;
            sv_ctl     = {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        data_t pat;
        data_t w;
        int    seen0;
        pat = 128'h0F0E0D0C0B0A09080706050403020100;

        srst_i              = 1'b1;
        ast_valid_i         = 1'b0;
        ast_data_i          = '0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_empty_i         = '0;
        ast_channel_i       = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", ast_valid_o, 0);
        check("rst_ready", ast_ready_o, 0);
        check("rst_outputs",
              {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, 0);
        tick();
        srst_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ast_ready_o, 1);
        tick();

        // Directed: full word, short EOP words
        ready_mode = 1;
        send_word(pat, 1'b1, 1'b1, 4'd0, 10'h055);
        send_word(pat, 1'b1, 1'b1, 4'd11, 10'h0AA);
        send_word(pat, 1'b1, 1'b1, 4'd8, 10'h3FF);
        wait_drain(50);

        // Three-word packet back to back
        rec_q.delete();
        rec_en = 1'b1;
        send_word(pat, 1'b1, 1'b0, 4'd5, 10'h123);
        send_word(~pat, 1'b0, 1'b0, 4'd0, 10'h123);
        send_word({pat[63:0], pat[127:64]}, 1'b0, 1'b1, 4'd0, 10'h123);
        @(negedge clk);
        #1;
        rec_en = 1'b0;
        tick();
        check("ready_pattern_len", rec_q.size(), 6);
        for (int i = 0; i < 6 && i < rec_q.size(); i++) begin
            check($sformatf("ready_pattern_%0d", i), rec_q[i], (i % 2 == 0) ? 1 : 0);
        end
        wait_drain(50);

        // Source stall during beat 0
        ready_mode = 0;
        send_word(~pat, 1'b1, 1'b1, 4'd0, 10'h2C1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready_low", ast_ready_o, 0);
            tick();
        end
        ready_mode = 1;
        wait_drain(50);

        // Reset in the middle of a word
        ready_mode = 0;
        send_word(pat, 1'b1, 1'b0, 4'd0, 10'h011);
        tick();
        srst_i = 1'b1;
        exp_q.delete();
        in_pkt_m = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", ast_valid_o, 0);
        check("rst_mid_ready", ast_ready_o, 0);
        tick();
        srst_i     = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        check("ready_after_mid_rst", ast_ready_o, 1);
        check("valid_after_mid_rst", ast_valid_o, 0);
        tick();
        seen0 = beats_seen;
        repeat (5) tick();
        check("no_beats_after_rst", beats_seen, seen0);
        send_word(~pat, 1'b0, 1'b0, 4'd0, 10'h077);
        wait_drain(50);

        // Random traffic with random source backpressure
        ready_mode = 2;
        for (int k = 0; k < 80; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            send_word(w, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                      empty_t'($urandom_range(0, BYTES_IN - 1)), channel_t'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        ready_mode = 1;
        wait_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
